seq_divider_pipe: RTL and testbench

- Parametrised iterative restoring divider: one quotient bit per clock, WIDTH-bit operands.
- Adds valid/ready handshakes, per-operation signed/unsigned mode, divide-by-zero and signed-overflow flags, and result hold under backpressure.
- Sits between the Snell-law datapath and any stage needing a quotient/remainder (e.g., sine-ratio normalisation).
- Replaces the free-running 16-bit divider, which had no start/done indication.

---
 rtl/seq_divider_pipe_pkg.sv | 21 ++
 rtl/seq_divider_pipe_if.sv | 30 +++
 rtl/seq_divider_pipe_div_step.sv | 27 ++
 rtl/seq_divider_pipe.sv | 131 +++++++++++++
 tb/tb_seq_divider_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pipe_pkg.sv
// Shared types and constants for the sequential divider.
// The package defines the FSM state encoding, the default operand width,
// and a helper that sizes the iteration counter.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // The counter runs 0..WIDTH-1, so $clog2(WIDTH) bits are enough.
  // The lower bound keeps the width at least one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_divider_pipe_if.sv
// Handshake and data bundle for seq_divider_pipe.
//   in_valid/in_ready   : operand handshake (in_signed, dividend, divisor)
//   out_valid/out_ready : result handshake (quo, rem, div_by_zero, ovf)
// The master modport is the side that supplies operands and consumes results.
// The slave modport is the divider side.
interface seq_divider_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             div_by_zero;
  logic             ovf;

  modport master (
    output in_valid, in_signed, dividend, divisor, out_ready,
    input  in_ready, out_valid, quo, rem, div_by_zero, ovf
  );

  modport slave (
    input  in_valid, in_signed, dividend, divisor, out_ready,
    output in_ready, out_valid, quo, rem, div_by_zero, ovf
  );
endinterface

// File: rtl/seq_divider_pipe_div_step.sv
// One combinational restoring-division iteration.
//   rem_in  : partial remainder from the previous iteration (always < divisor)
//   bit_in  : next dividend bit, MSB first
//   divisor : unsigned divisor magnitude (nonzero)
//   rem_out : partial remainder after this iteration
//   q_bit   : quotient bit produced by this iteration
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH:0] partial;
  logic [WIDTH:0] trial;

  // rem_in < divisor, so the shifted partial is < 2*divisor. The trial
  // difference therefore fits in WIDTH+1 bits, and its MSB is a clean
  // borrow/sign indicator.
  assign partial = {rem_in, bit_in};
  assign trial   = partial - {1'b0, divisor};
  assign q_bit   = ~trial[WIDTH];
  // When the trial fails, partial < divisor, so its top bit is zero.
  assign rem_out = q_bit ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
endmodule

// File: rtl/seq_divider_pipe.sv
// Iterative restoring divider: one quotient bit per clock, WIDTH-bit operands.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset; discards any operation in flight
//   bus : seq_divider_pipe_if.slave
//         operands are accepted on in_valid && in_ready;
//         results are held until out_valid && out_ready.
// Latency from accept: WIDTH+2 cycles, or 1 cycle when the divisor is zero.
module seq_divider_pipe
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  seq_divider_pipe_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state_reg;
  state_t state_next;

  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] dvd_reg;   // dividend magnitude shifting out; quotient shifting in
  logic [WIDTH-1:0] dsr_reg;   // divisor magnitude
  logic [WIDTH-1:0] prem_reg;  // partial remainder
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] rem_reg;
  logic             sign_q_reg;
  logic             sign_r_reg;
  logic             ovf_pend_reg;
  logic             dbz_reg;
  logic             ovf_reg;

  logic             last_step;
  logic             divisor_zero;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  assign last_step    = (cnt_reg == CW'(WIDTH - 1));
  assign divisor_zero = (bus.divisor == '0);

  // Two's-complement magnitude. MIN maps to 2^(WIDTH-1), which is exact as
  // an unsigned value.
  assign dvd_mag = (bus.in_signed && bus.dividend[WIDTH-1]) ? (~bus.dividend + 1'b1) : bus.dividend;
  assign dsr_mag = (bus.in_signed && bus.divisor[WIDTH-1])  ? (~bus.divisor + 1'b1)  : bus.divisor;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (prem_reg),
    .bit_in (dvd_reg[WIDTH-1]),
    .divisor(dsr_reg),
    .rem_out(step_rem),
    .q_bit  (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (bus.in_valid) state_next = divisor_zero ? DONE : CALC;
      CALC:    if (last_step) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      dvd_reg      <= '0;
      dsr_reg      <= '0;
      prem_reg     <= '0;
      quo_reg      <= '0;
      rem_reg      <= '0;
      sign_q_reg   <= 1'b0;
      sign_r_reg   <= 1'b0;
      ovf_pend_reg <= 1'b0;
      dbz_reg      <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            cnt_reg      <= '0;
            dvd_reg      <= dvd_mag;
            dsr_reg      <= dsr_mag;
            prem_reg     <= '0;
            sign_q_reg   <= bus.in_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            sign_r_reg   <= bus.in_signed & bus.dividend[WIDTH-1];
            // Only flagged here; the magnitude path already yields MIN, 0.
            ovf_pend_reg <= bus.in_signed && (bus.dividend == MIN_VAL) && (bus.divisor == '1);
            ovf_reg      <= 1'b0;
            dbz_reg      <= divisor_zero;
            if (divisor_zero) begin
              quo_reg <= '1;
              rem_reg <= bus.dividend;
            end
          end
        end
        CALC: begin
          prem_reg <= step_rem;
          dvd_reg  <= {dvd_reg[WIDTH-2:0], step_q};
          cnt_reg  <= cnt_reg + 1'b1;
        end
        FIX: begin
          quo_reg <= sign_q_reg ? (~dvd_reg + 1'b1) : dvd_reg;
          rem_reg <= sign_r_reg ? (~prem_reg + 1'b1) : prem_reg;
          ovf_reg <= ovf_pend_reg;
        end
        default: ;  // DONE holds the results.
      endcase
    end
  end

  assign bus.in_ready    = (state_reg == IDLE);
  assign bus.out_valid   = (state_reg == DONE);
  assign bus.quo         = quo_reg;
  assign bus.rem         = rem_reg;
  assign bus.div_by_zero = dbz_reg;
  assign bus.ovf         = ovf_reg;
endmodule

// File: tb/tb_seq_divider_pipe.sv
// Self-checking bench for seq_divider_pipe (WIDTH=16).
// Expected results are computed by a behavioural model and queued at drive time.
// They are popped and compared when the DUT presents out_valid.
module tb_seq_divider_pipe;
  localparam int W = 16;
  localparam logic [W-1:0] MIN_VAL = 16'h8000;

  typedef struct packed {
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dbz;
    logic         ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  seq_divider_pipe_if #(.WIDTH(W)) bus ();

  seq_divider_pipe #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    res_t r;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    r = '0;
    if (b == 0) begin
      r.quo = '1;
      r.rem = a;
      r.dbz = 1'b1;
    end else if (!sgn) begin
      r.quo = a / b;
      r.rem = a % b;
    end else if (a == MIN_VAL && b == '1) begin
      r.quo = MIN_VAL;
      r.rem = '0;
      r.ovf = 1'b1;
    end else begin
      r.quo = sa / sb;
      r.rem = sa % sb;
    end
    return r;
  endfunction

  function automatic res_t observed();
    res_t r;
    r.quo = bus.quo;
    r.rem = bus.rem;
    r.dbz = bus.div_by_zero;
    r.ovf = bus.ovf;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queues the model result, drives one accepted operation, and waits for out_valid.
  // lat is the cycle number (accept cycle = 0) where out_valid was first seen.
  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn, output int lat);
    int t;
    exp_q.push_back(model(a, b, sgn));
    t = 0;
    while (!bus.in_ready && t < 100) begin
      tick();
      t++;
    end
    bus.in_valid  = 1'b1;
    bus.in_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    tick();
    bus.in_valid = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    checks++;
    if (!bus.out_valid) begin
      errors++;
      $display("FAIL out_valid_timeout a=%h b=%h: got no out_valid, required one within 100 cycles", a, b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b req=1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b req=0", bus.out_valid); end
    checks++;
    if (observed() !== res_t'(0)) begin errors++; $display("FAIL reset_outputs got=%h req=0", observed()); end
    $display("reset: in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);
  endtask

  task automatic test_unsigned();
    int lat;
    res_t e;
    send_op(16'd100, 16'd7, 1'b0, lat);
    e = exp_q.pop_front();
    checks++;
    if (lat !== 18) begin errors++; $display("FAIL u100_7_latency got=%0d req=18", lat); end
    checks++;
    if (observed() !== e) begin errors++; $display("FAIL u100_7_result got=%h req=%h", observed(), e); end
    $display("unsigned 100/7: quo=%0d rem=%0d lat=%0d", bus.quo, bus.rem, lat);
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL u100_7_ready_after got in_ready=%b out_valid=%b req 1/0", bus.in_ready, bus.out_valid);
    end
    send_op(16'hFFFF, 16'h0001, 1'b0, lat);
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e || lat !== 18) begin
      errors++; $display("FAIL uffff_1 got=%h lat=%0d req=%h lat=18", observed(), lat, e);
    end
    $display("unsigned ffff/1: quo=%h rem=%h", bus.quo, bus.rem);
    tick();
  endtask

  task automatic test_signed();
    int lat;
    res_t e;
    logic [W-1:0] a_tab [3] = '{16'hFFF9, 16'h0007, 16'hFFF9};
    logic [W-1:0] b_tab [3] = '{16'h0002, 16'hFFFE, 16'hFFFE};
    logic [W-1:0] q_tab [3] = '{16'hFFFD, 16'hFFFD, 16'h0003};
    logic [W-1:0] r_tab [3] = '{16'hFFFF, 16'h0001, 16'hFFFF};
    for (int i = 0; i < 3; i++) begin
      send_op(a_tab[i], b_tab[i], 1'b1, lat);
      e = exp_q.pop_front();
      checks++;
      if (bus.quo !== q_tab[i] || bus.rem !== r_tab[i] || bus.div_by_zero !== 1'b0 || bus.ovf !== 1'b0 || e.quo !== q_tab[i]) begin
        errors++;
        $display("FAIL signed_%0d got quo=%h rem=%h dbz=%b ovf=%b req quo=%h rem=%h", i, bus.quo, bus.rem, bus.div_by_zero, bus.ovf, q_tab[i], r_tab[i]);
      end
      $display("signed %h/%h: quo=%h rem=%h", a_tab[i], b_tab[i], bus.quo, bus.rem);
      tick();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    res_t e;
    send_op(16'd1234, 16'd0, 1'b0, lat);
    e = exp_q.pop_front();
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL dbz_latency got=%0d req=1", lat); end
    checks++;
    if (observed() !== e) begin errors++; $display("FAIL dbz_unsigned got=%h req=%h", observed(), e); end
    $display("div0 1234/0: quo=%h rem=%0d dbz=%b", bus.quo, bus.rem, bus.div_by_zero);
    tick();
    send_op(16'hFFFB, 16'd0, 1'b1, lat);
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e || lat !== 1) begin
      errors++; $display("FAIL dbz_signed got=%h lat=%0d req=%h lat=1", observed(), lat, e);
    end
    $display("div0 signed fffb/0: quo=%h rem=%h dbz=%b", bus.quo, bus.rem, bus.div_by_zero);
    tick();
    // The next normal op must clear the flag.
    send_op(16'd20, 16'd6, 1'b0, lat);
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e) begin errors++; $display("FAIL dbz_clear got=%h req=%h", observed(), e); end
    $display("after div0 20/6: quo=%0d rem=%0d dbz=%b", bus.quo, bus.rem, bus.div_by_zero);
    tick();
  endtask

  task automatic test_overflow();
    int lat;
    res_t e;
    send_op(MIN_VAL, 16'hFFFF, 1'b1, lat);
    e = exp_q.pop_front();
    checks++;
    if (bus.quo !== 16'h8000 || bus.rem !== 16'h0000 || bus.ovf !== 1'b1 || bus.div_by_zero !== 1'b0 || observed() !== e) begin
      errors++; $display("FAIL overflow got=%h req quo=8000 rem=0000 ovf=1", observed());
    end
    $display("overflow 8000/ffff: quo=%h rem=%h ovf=%b", bus.quo, bus.rem, bus.ovf);
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    int seen;
    res_t e;
    bus.out_ready = 1'b0;
    send_op(16'd50, 16'd6, 1'b0, lat);
    e = exp_q.pop_front();
    checks++;
    if (lat !== 18) begin errors++; $display("FAIL bp_latency got=%0d req=18", lat); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (observed() !== e || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d got=%h ov=%b ir=%b req=%h ov=1 ir=0", i, observed(), bus.out_valid, bus.in_ready, e);
      end
      if (i == 2) begin
        bus.in_valid = 1'b1;
        bus.in_signed = 1'b0;
        bus.dividend = 16'd77;
        bus.divisor = 16'd5;
      end
      tick();
      bus.in_valid = 1'b0;
    end
    $display("backpressure 50/6 held: quo=%0d rem=%0d", bus.quo, bus.rem);
    bus.out_ready = 1'b1;
    checks++;
    if (observed() !== e) begin errors++; $display("FAIL bp_release got=%h req=%h", observed(), e); end
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_after got in_ready=%b out_valid=%b req 1/0", bus.in_ready, bus.out_valid);
    end
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL bp_ignored_pulse got %0d out_valid cycles req 0", seen); end
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.in_valid = 1'b1;
    bus.in_signed = 1'b0;
    bus.dividend = 16'd1000;
    bus.divisor = 16'd3;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.quo !== '0 || bus.rem !== '0) begin
      errors++;
      $display("FAIL reset_mid got ov=%b ir=%b quo=%h rem=%h req 0/1/0/0", bus.out_valid, bus.in_ready, bus.quo, bus.rem);
    end
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_mid_no_result got %0d out_valid cycles req 0", seen); end
    $display("reset mid-calc: in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);
  endtask

  task automatic test_after_reset();
    int lat;
    res_t e;
    send_op(16'd9, 16'd3, 1'b0, lat);
    e = exp_q.pop_front();
    checks++;
    if (bus.quo !== 16'd3 || bus.rem !== 16'd0 || observed() !== e || lat !== 18) begin
      errors++; $display("FAIL after_reset_9_3 got=%h lat=%0d req quo=3 rem=0 lat=18", observed(), lat);
    end
    $display("after reset 9/3: quo=%0d rem=%0d", bus.quo, bus.rem);
    tick();
  endtask

  task automatic test_random();
    int lat;
    res_t e;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic sgn;
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom);
      b = (i % 4 == 0) ? W'($urandom_range(0, 3)) : W'($urandom) >> $urandom_range(0, 14);
      if (i == 5) begin a = MIN_VAL; b = 16'h0003; end
      if (i == 6) begin a = 16'h7FFF; b = MIN_VAL; end
      sgn = 1'($urandom);
      send_op(a, b, sgn, lat);
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e || lat !== ((b == 0) ? 1 : 18)) begin
        errors++; $display("FAIL random_%0d a=%h b=%h s=%b got=%h lat=%0d req=%h", i, a, b, sgn, observed(), lat, e);
      end
      $display("random %0d: %h/%h s=%b quo=%h rem=%h", i, a, b, sgn, bus.quo, bus.rem);
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_after_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
